// File: rtl/hex_entry_fifo_pkg.sv
// Shared PDU keypad definitions: key positions in the synced input vector,
// event priority classes and a constant-safe clog2.
package hex_entry_fifo_pkg;

  localparam int KEY_DEL   = 16;
  localparam int KEY_CLR   = 17;
  localparam int KEY_ENTER = 18;
  localparam int KEY_NUM   = 19;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLR,
    EV_ENTER,
    EV_DEL,
    EV_DIGIT
  } ev_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hex_entry_fifo_sync_fifo.sv
// First-word-fall-through commit buffer; the head slot is presented directly
// and a full buffer accepts a push when the head is popped in the same cycle.
module sync_fifo
  import hex_entry_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hex_entry_fifo.sv
// Hex keypad entry: synchronised edge detection with lockout, prioritised
// key events driving a shift-entry register, and Enter committing to a FIFO.
module hex_entry_fifo
  import hex_entry_fifo_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   hd,
  input  logic                          del,
  input  logic                          clr,
  input  logic                          enter,
  output logic [4*DIGITS-1:0]           io_din,
  output logic [clog2(DIGITS+1)-1:0]    digits,
  output logic [4*DIGITS-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          ovf
);

  localparam int WIDTH = 4 * DIGITS;
  localparam int DW    = clog2(DIGITS + 1);
  localparam int LW    = clog2(DEB_CYCLES + 1);

  logic [KEY_NUM-1:0] w_raw;
  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] r_prev;
  logic [KEY_NUM-1:0] w_edge;
  logic [LW-1:0]      r_lock;
  ev_t                w_ev;
  logic [3:0]         w_num;
  logic               w_full;
  logic               w_can_push;
  logic               w_push;
  logic [WIDTH-1:0]   r_io_din;
  logic [DW-1:0]      r_digits;
  logic               r_ovf;

  assign w_raw  = {enter, clr, del, hd};
  assign w_edge = r_sync2 & ~r_prev;

  // Events are only classified while the lockout counter is idle, so a
  // discarded edge never reaches the entry register or the FIFO.
  always_comb begin
    w_ev  = EV_NONE;
    w_num = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (w_edge[i]) w_num = 4'(i);
    end
    if (r_lock == '0) begin
      if (w_edge[KEY_CLR])        w_ev = EV_CLR;
      else if (w_edge[KEY_ENTER]) w_ev = EV_ENTER;
      else if (w_edge[KEY_DEL])   w_ev = EV_DEL;
      else if (|w_edge[15:0])     w_ev = EV_DIGIT;
    end
  end

  // A full FIFO always has a valid head, so out_ready alone implies a pop.
  assign w_can_push = !w_full || out_ready;
  assign w_push     = (w_ev == EV_ENTER) && w_can_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_lock   <= '0;
      r_io_din <= '0;
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_ovf   <= 1'b0;
      if (r_lock != '0)       r_lock <= r_lock - LW'(1);
      else if (w_ev != EV_NONE) r_lock <= LW'(DEB_CYCLES);
      case (w_ev)
        EV_CLR: begin
          r_io_din <= '0;
          r_digits <= '0;
        end
        EV_ENTER: begin
          if (w_can_push) begin
            r_io_din <= '0;
            r_digits <= '0;
          end else begin
            r_ovf <= 1'b1;
          end
        end
        EV_DEL: begin
          if (r_digits != '0) begin
            r_io_din <= r_io_din >> 4;
            r_digits <= r_digits - DW'(1);
          end
        end
        EV_DIGIT: begin
          if (r_digits < DW'(DIGITS)) begin
            r_io_din <= (r_io_din << 4) | WIDTH'(w_num);
            r_digits <= r_digits + DW'(1);
          end else begin
            r_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (r_io_din),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_full  (w_full)
  );

  assign io_din = r_io_din;
  assign digits = r_digits;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_hex_entry_fifo.sv
// Bench for hex_entry_fifo: directed keypad scenarios plus random key traffic,
// all checked each cycle against a queue-based model of entry and FIFO.
module tb_hex_entry_fifo;

  localparam int DIGITS = 8;
  localparam int DEPTH  = 4;
  localparam int DEB    = 4;
  localparam int K_DEL  = 16;
  localparam int K_CLR  = 17;
  localparam int K_ENT  = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] keys = '0;
  logic        out_ready = 1'b0;
  logic [31:0] io_din;
  logic [3:0]  digits;
  logic [31:0] out_data;
  logic        out_valid;
  logic        ovf;

  hex_entry_fifo #(
    .DIGITS     (DIGITS),
    .DEPTH      (DEPTH),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hd        (keys[15:0]),
    .del       (keys[K_DEL]),
    .clr       (keys[K_CLR]),
    .enter     (keys[K_ENT]),
    .io_din    (io_din),
    .digits    (digits),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  logic [31:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: raw-sample history, digit list (oldest first), FIFO contents queue.
  logic [18:0] hist[$];
  int          dq[$];
  logic [31:0] mq[$];
  int          cyc;
  int          last_acc;
  logic        m_ovf;
  logic [18:0] m_ev;
  bit          m_pop;
  bit          m_push;
  int          m_num;

  function automatic logic [31:0] entry_val();
    logic [31:0] v;
    v = '0;
    foreach (dq[i]) v = (v << 4) | 32'(dq[i]);
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = {19'd0, 19'd0, 19'd0};
      dq.delete();
      mq.delete();
      cyc = 0;
      last_acc = -100;
      m_ovf = 1'b0;
    end else begin
      cyc++;
      hist.push_front(keys);
      m_ev = hist[2] & ~hist[3];
      void'(hist.pop_back());
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = 1'b0;
      m_ovf  = 1'b0;
      if (m_ev != '0 && cyc > last_acc + DEB) begin
        last_acc = cyc;
        if (m_ev[K_CLR]) begin
          dq.delete();
        end else if (m_ev[K_ENT]) begin
          if (mq.size() < DEPTH || m_pop) m_push = 1'b1;
          else m_ovf = 1'b1;
        end else if (m_ev[K_DEL]) begin
          if (dq.size() > 0) void'(dq.pop_back());
        end else begin
          m_num = 0;
          for (int i = 0; i < 16; i++) if (m_ev[i]) m_num = i;
          if (dq.size() < DIGITS) dq.push_back(m_num);
          else m_ovf = 1'b1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(entry_val());
        dq.delete();
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("io_din", io_din, entry_val());
      chk("digits", 32'(digits), 32'(dq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (ovf) ovf_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input int idx);
    keys = '0;
    keys[idx] = 1'b1;
    tick(3);
    keys = '0;
    tick(7);
  endtask

  task automatic enter_val(input logic [7:0] v);
    key(int'(v[7:4]));
    key(int'(v[3:0]));
    key(K_ENT);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    chk("reset_io_din", io_din, 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);

    key(1); key(2); key(10); key(15);
    chk("seq1_val", io_din, 32'h000012AF);
    chk("seq1_digits", 32'(digits), 32'd4);
    chk("seq1_no_ovf", 32'(ovf_seen), 32'd0);

    key(K_CLR);
    for (int i = 0; i < 8; i++) key(i);
    key(9);
    chk("full_val", io_din, 32'h01234567);
    chk("full_digits", 32'(digits), 32'd8);
    chk("full_ovf", 32'(ovf_seen), 32'd1);
    key(K_DEL);
    chk("del_val", io_din, 32'h00123456);
    chk("del_digits", 32'(digits), 32'd7);
    key(K_CLR); key(K_DEL);
    chk("del_empty_val", io_din, 32'h0);
    chk("del_empty_ovf", 32'(ovf_seen), 32'd1);

    keys = '0; keys[3] = 1'b1; keys[12] = 1'b1; tick(3); keys = '0; tick(7);
    chk("multi_digit", io_din, 32'h0000000C);
    keys = '0; keys[K_CLR] = 1'b1; keys[5] = 1'b1; tick(3); keys = '0; tick(7);
    chk("clr_prio", io_din, 32'h0);
    keys = '0; keys[1] = 1'b1; tick(1); keys = '0; tick(1);
    keys[2] = 1'b1; tick(1); keys = '0; tick(8);
    chk("lockout_val", io_din, 32'h00000001);
    chk("lockout_digits", 32'(digits), 32'd1);

    key(K_CLR);
    enter_val(8'h11); enter_val(8'h22); enter_val(8'h33); enter_val(8'h44);
    enter_val(8'h55);
    chk("fifo_head", out_data, 32'h11);
    chk("fifo_valid", 32'(out_valid), 32'd1);
    chk("fifo_full_ovf", 32'(ovf_seen), 32'd2);
    chk("fifo_full_keep", io_din, 32'h55);
    got.delete();
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("drain_order", got[i], 32'(8'h11 * (i + 1)));

    key(K_CLR);
    enter_val(8'h11); enter_val(8'h22); enter_val(8'h33); enter_val(8'h44);
    key(6); key(6);
    got.delete();
    keys = '0; keys[K_ENT] = 1'b1; tick(1);
    keys = '0; tick(1);
    out_ready = 1'b1; tick(1);
    out_ready = 1'b0; tick(7);
    chk("pushpop_ovf", 32'(ovf_seen), 32'd2);
    chk("pushpop_head", out_data, 32'h22);
    chk("pushpop_entry", io_din, 32'h0);
    out_ready = 1'b1; tick(5); out_ready = 1'b0;
    chk("pushpop_count", 32'(got.size()), 32'd5);
    if (got.size() == 5) begin
      chk("pushpop_first", got[0], 32'h11);
      chk("pushpop_pen", got[3], 32'h44);
      chk("pushpop_last", got[4], 32'h66);
    end

    enter_val(8'h11); enter_val(8'h22);
    key(3); key(4);
    #2 rst = 1'b1;
    #1;
    chk("rst_io_din", io_din, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_digits", 32'(digits), 32'h0);
    tick(2);
    rst = 1'b0;
    key(7);
    chk("post_rst_val", io_din, 32'h7);
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1: begin
          keys = '0;
          keys[$urandom_range(0, 18)] = 1'b1;
        end
        2: begin
          keys = '0;
          keys[$urandom_range(0, 15)] = 1'b1;
          keys[$urandom_range(0, 18)] = 1'b1;
        end
        3: begin
          keys = '0;
          keys[K_ENT] = 1'b1;
        end
        default: keys = '0;
      endcase
    end
    keys = '0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_entry_fifo.md
Name: hex_entry_fifo

Overview:
- Parametrised successor of the PDU hex-keypad input block.
- Turns raw 16-key hex pad, delete, clear and enter levels into a WIDTH-bit shift-entry value with per-digit count.
- Enter commits the value into a DEPTH-entry first-word-fall-through FIFO. The CPU drains the FIFO through a valid/ready handshake.
- Sits between the PDU switch/button inputs and the CPU IO read port.

Parameters:
- DIGITS, 8, max hex digits held in the entry register; WIDTH = 4*DIGITS.
- DEPTH, 4, commit FIFO entries (power of two, >=2).
- DEB_CYCLES, 16, lockout cycles after any accepted event (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- hd  input  16  raw hex key levels, bit i = digit i
- del  input  1  raw delete key level
- clr  input  1  raw clear key level
- enter  input  1  raw commit key level
- io_din  output  WIDTH  live entry value (digit 0 = newest, in LSBs)
- digits  output  $clog2(DIGITS+1)  digits currently entered
- out_data  output  WIDTH  FIFO head value
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- ovf  output  1  one-cycle pulse: digit rejected (entry full) or commit rejected (FIFO full)

Behaviour:
- Reset (async assert, sync release):
  - io_din=0, digits=0, out_valid=0, out_data=0, ovf=0.
  - FIFO empty, lockout counter 0, sync/edge registers 0.
  - Reset mid-entry or mid-handshake discards everything.
- Input path:
  - All 19 raw inputs pass a 2-flop synchroniser, then a previous-value register.
  - event = synced & ~prev (rising edges only). Held keys produce one event.
- Lockout:
  - Any accepted event loads the counter with DEB_CYCLES.
  - While counter != 0, all events are discarded and the counter decrements.
  - Edges occurring during lockout are lost; they are not queued.
- Priority when several events coincide in one cycle: clr > enter > del > digit.
  - Multiple digit edges: the highest index wins.
- Latency: a key sampled high at edge N gives io_din/digits updated after edge N+2. A FIFO push is visible at out_valid after the same edge.
- Digit event, num:
  - If digits<DIGITS: io_din <= {io_din[WIDTH-5:0], num}; digits++.
  - If digits==DIGITS: entry unchanged; ovf=1 for one cycle.
- del: if digits>0, io_din <= io_din>>4 and digits--. If digits==0, no-op with no ovf.
- clr: io_din=0, digits=0. FIFO is untouched.
- enter:
  - If the FIFO can accept, push io_din (including 0 when digits==0), then io_din=0 and digits=0.
  - Otherwise entry is retained and ovf=1.
- FIFO:
  - out_data is the head register (first-word fall-through); out_valid = count!=0.
  - Pop when out_valid&out_ready. out_ready with out_valid=0 is ignored.
  - "Can accept" = count<DEPTH, or count==DEPTH with a pop in the same cycle (push and pop together when full are both performed).
  - Push and pop together at count 1: the head becomes the pushed value next cycle, out_valid stays 1.
  - Pointers wrap modulo DEPTH. Count is DEPTH+1 states wide.
- out_data and out_valid must stay stable while out_valid=1 and out_ready=0.
- ovf is registered, high for exactly one cycle per rejected event, and never high otherwise.

Decomposition:
- Shared PDU package holds:
  - Key-index constants: DEL, CLR, ENTER bit positions in the concatenated synced vector.
  - Function clog2.
  - Event-priority enum: EV_NONE, EV_CLR, EV_ENTER, EV_DEL, EV_DIGIT.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) for the commit buffer. The keypad front-end, priority encoder and entry register stay in the top module.

Test Plan (DIGITS=8, DEPTH=4, DEB_CYCLES=4):
- Reset, then keys 1,2,A,F each pulsed high 3 cycles and spaced 10 cycles apart -> io_din=0x000012AF, digits=4, ovf never high.
- 8 digits 0..7 entered, then 9 -> io_din=0x01234567 unchanged, digits=8, ovf one pulse. Then del -> io_din=0x00123456, digits=7. With 0 digits, del -> no change.
- hd[3] and hd[12] rise in the same cycle -> digit C entered. clr and hd[5] together -> io_din=0. A second key 2 cycles after an accepted event -> ignored.
- Enter values 0x11, 0x22, 0x33, 0x44, 0x55 with out_ready=0 -> out_valid=1 with out_data=0x11. Fifth enter gives ovf, io_din stays 0x55. Then out_ready=1 -> reads 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0.
- FIFO full, and enter (0x66) and out_ready=1 in the same cycle -> pop 0x11, push 0x66, no ovf. Later drain order ends ...0x44,0x66.
- Assert rst mid-entry with 2 FIFO entries -> immediately io_din=0, out_valid=0, digits=0. After release, normal entry resumes.
